vga_text_render: RTL and testbench
==================================

# vga_text_render

Character-cell text renderer directly downstream of the VGA timing generator. Consumes `hdata`/`vdata`/`blank`/`hsync`/`vsync` and fetches character codes from an external synchronous text RAM and glyph rows from an external synchronous font ROM. Drives 12-bit RGB with sync and blank delayed to stay pixel-aligned. Fixed 8x16 glyphs; defaults fit 1024x768 (128x48 cells).

## Interface

Parameters:
- `WIDTH`, 12: width of `hdata`/`vdata`.
- `COL_BITS`, 7: column index bits; column = `hdata[COL_BITS+2:3]`.
- `ROW_BITS`, 6: row index bits; row = `vdata[ROW_BITS+3:4]`.
- `HSYNC_POL`, 0: active level of `hsync_in`/`hsync`.
- `VSYNC_POL`, 0: active level of `vsync_in`/`vsync`.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hdata`, `vdata`  in  WIDTH each  pixel coordinates from the timing generator.
- `hsync_in`, `vsync_in`, `blank_in`  in  1 each  timing-generator syncs and blank.
- `text_addr`  out  ROW_BITS+COL_BITS  text RAM address, `{row, col}`.
- `text_data`  in  16  `[7:0]` char code, `[11:8]` fg index, `[15:12]` bg index; valid the cycle after the RAM samples `text_addr`.
- `font_addr`  out  12  font ROM address, `{char[7:0], glyph_row[3:0]}`.
- `font_data`  in  8  glyph row, bit 7 = leftmost pixel; valid the cycle after the ROM samples `font_addr`.
- `cursor_col`  in  COL_BITS  cursor column.
- `cursor_row`  in  ROW_BITS  cursor row.
- `rgb`  out  12  `{R[3:0],G[3:0],B[3:0]}`.
- `hsync`, `vsync`, `blank`  out  1 each  delayed, aligned copies.

## Operation

- Stage A (block register): `text_addr <= {row, col}`. Captures `hdata[2:0]`, `vdata[3:0]`, col, row, syncs and blank into the delay pipe.
- Stage B (external RAM register): the RAM samples `text_addr`.
- Stage C (block register): `font_addr <= {text_data[7:0], glyph_row}`. Latches fg/bg indices.
- Stage D (external ROM register): the ROM samples `font_addr`.
- Stage E (block register): `pix = font_data[7 - x[2:0]]` using the x carried in the delay pipe. `rgb <= blank_d ? 0 : palette(pix ? fg : bg)`.
- Palette is a fixed 16-entry CGA table: 0=000, 1=00A, 2=0A0, 3=0AA, 4=A00, 5=A0A, 6=A50, 7=AAA, 8=555, 9=55F, A=5F5, B=5FF, C=F55, D=F5F, E=FF5, F=FFF (hex).
- Coordinates beyond the cell grid occur only during blanking. The address uses the truncated bits and is not clamped. The output is black because of blank.
- Frame counter: a 5-bit counter increments on each transition of `vsync_in` into the `VSYNC_POL` level and wraps 31 to 0.

## Timing

- Latency: a pixel presented on inputs in cycle t appears on `rgb`/`hsync`/`vsync`/`blank` in cycle t+5.
- Syncs and blank pass through a 5-deep delay. Their values and polarity are unchanged.
- `text_addr` is valid at t+1. `font_addr` is valid at t+3.
- The block generates one address per clock, with no stalls and no handshake. The RAM and ROM must have exactly one cycle of read latency.
- Reset values:
  - `rgb`=0, `blank`=1.
  - `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL (inactive).
  - `text_addr`=0, `font_addr`=0.
  - All pipe registers inactive; frame counter 0.
- Reset mid-frame: outputs go to their reset values immediately (asynchronously). Valid pixels resume 5 cycles after `rst_n` deasserts; pipe contents are flushed as blank.
- `cursor_col`/`cursor_row` are sampled at stage A alongside col/row. A cursor position change takes effect at the next pixel.

## Configuration

- `VGA_TEXT_CURSOR_EN` defined: underline cursor.
  - When the stage-A cell equals (`cursor_row`,`cursor_col`), glyph_row is 14 or 15, and frame counter bit 4 is 0, pix is forced to 1 (fg colour).
  - Blink: on for 16 frames, off for 16 frames; visible immediately after reset.
- Macro undefined:
  - Cursor ports remain present but are ignored.
  - Frame counter is not implemented.
  - Output is a pure glyph render.

## Test plan

- Reset: hold `rst_n`=0 mid-line → `rgb`=000, `blank`=1, `hsync`/`vsync` inactive. Release → the first non-blank pixel appears exactly 5 cycles after the corresponding input.
- Addressing: `hdata`=0x3F9, `vdata`=0x2FE → `text_addr`={0x2F, 0x7F}=0x17FF at t+1. With `text_data`=0x1F41 → `font_addr`=0x41E at t+3.
- Pixel select: `font_data`=0x81, fg=F, bg=1 → x=0 and x=7 give FFF; x=1..6 give 00A.
- Blank: `blank_in`=1 with `font_data`=0xFF → `rgb`=000 five cycles later; `blank`=1 aligned with it.
- Sync alignment: 1-cycle `hsync_in` pulse at cycle 100 → `hsync` pulse at cycle 105, same polarity.
- Cursor (macro on): cursor (2,3), char 0x20 with all-zero glyph, fg=E → cell rows 14–15 show FF5 during frames 0–15, bg during frames 16–31, visible again at frame 32.

Source files
------------

// File: rtl/vga_text_render.sv
// Character-cell text renderer: 8x16 glyphs, external 1-cycle text RAM and font ROM, 5-cycle pixel latency.
// Optional underline blinking cursor enabled by defining VGA_TEXT_CURSOR_EN.
module vga_text_render #(
  parameter int WIDTH     = 12,
  parameter int COL_BITS  = 7,
  parameter int ROW_BITS  = 6,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             hdata,
  input  logic [WIDTH-1:0]             vdata,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         blank_in,
  output logic [ROW_BITS+COL_BITS-1:0] text_addr,
  input  logic [15:0]                  text_data,
  output logic [11:0]                  font_addr,
  input  logic [7:0]                   font_data,
  input  logic [COL_BITS-1:0]          cursor_col,
  input  logic [ROW_BITS-1:0]          cursor_row,
  output logic [11:0]                  rgb,
  output logic                         hsync,
  output logic                         vsync,
  output logic                         blank
);

  // {blank, hsync, vsync} as they sit while idle
  localparam logic [2:0] CTL_IDLE = {1'b1, ~HSYNC_POL, ~VSYNC_POL};

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic [2:0]          ctl_pipe  [5];
  logic [2:0]          x_pipe    [4];
  logic [3:0]          grow_pipe [2];
  logic [3:0]          cur_pipe;
  logic [3:0]          fg_c, bg_c, fg_d, bg_d;
  logic                cursor_hit;
  logic                pix;
  logic                unused_coord;

  assign col = hdata[COL_BITS+2:3];
  assign row = vdata[ROW_BITS+3:4];
  assign unused_coord = ^{hdata, vdata};

  function automatic logic [11:0] cga(input logic [3:0] idx);
    logic [11:0] c;
    case (idx)
      4'h0: c = 12'h000;  4'h1: c = 12'h00A;  4'h2: c = 12'h0A0;  4'h3: c = 12'h0AA;
      4'h4: c = 12'hA00;  4'h5: c = 12'hA0A;  4'h6: c = 12'hA50;  4'h7: c = 12'hAAA;
      4'h8: c = 12'h555;  4'h9: c = 12'h55F;  4'hA: c = 12'h5F5;  4'hB: c = 12'h5FF;
      4'hC: c = 12'hF55;  4'hD: c = 12'hF5F;  4'hE: c = 12'hFF5;  default: c = 12'hFFF;
    endcase
    return c;
  endfunction

`ifdef VGA_TEXT_CURSOR_EN
  logic [4:0] frame_cnt;
  logic       vsync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      vsync_prev <= ~VSYNC_POL;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in == VSYNC_POL && vsync_prev != VSYNC_POL)
        frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // underline on glyph rows 14-15, lit while the frame counter is in its lower half
  assign cursor_hit = (row == cursor_row) && (col == cursor_col) &&
                      (vdata[3:1] == 3'b111) && !frame_cnt[4];
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_col, cursor_row};
  assign cursor_hit    = 1'b0;
`endif

  // bit 7 is the leftmost pixel, so 7-x is simply ~x
  assign pix = font_data[~x_pipe[3]] | cur_pipe[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_addr <= '0;
      font_addr <= '0;
      rgb       <= '0;
      fg_c      <= '0;
      bg_c      <= '0;
      fg_d      <= '0;
      bg_d      <= '0;
      cur_pipe  <= '0;
      for (int i = 0; i < 5; i++) ctl_pipe[i] <= CTL_IDLE;
      for (int i = 0; i < 4; i++) x_pipe[i] <= '0;
      for (int i = 0; i < 2; i++) grow_pipe[i] <= '0;
    end else begin
      text_addr    <= {row, col};
      ctl_pipe[0]  <= {blank_in, hsync_in, vsync_in};
      for (int i = 1; i < 5; i++) ctl_pipe[i] <= ctl_pipe[i-1];
      x_pipe[0]    <= hdata[2:0];
      for (int i = 1; i < 4; i++) x_pipe[i] <= x_pipe[i-1];
      grow_pipe[0] <= vdata[3:0];
      grow_pipe[1] <= grow_pipe[0];
      cur_pipe     <= {cur_pipe[2:0], cursor_hit};
      font_addr    <= {text_data[7:0], grow_pipe[1]};
      fg_c         <= text_data[11:8];
      bg_c         <= text_data[15:12];
      fg_d         <= fg_c;
      bg_d         <= bg_c;
      rgb          <= ctl_pipe[3][2] ? 12'h000 : cga(pix ? fg_d : bg_d);
    end
  end

  assign blank = ctl_pipe[4][2];
  assign hsync = ctl_pipe[4][1];
  assign vsync = ctl_pipe[4][0];

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: behavioural RAM/ROM plus a per-pixel reference model and expected-output queue.
// Honours VGA_TEXT_CURSOR_EN in the model when the design is built with the cursor.
module tb_vga_text_render;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] hdata, vdata;
  logic        hsync_in, vsync_in, blank_in;
  logic [12:0] text_addr;
  logic [15:0] text_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [11:0] rgb;
  logic        hsync, vsync, blank;

  always #5 clk = ~clk;

  vga_text_render dut (
    .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .blank(blank)
  );

  logic [15:0] tmem [0:8191];
  logic [7:0]  fmem [0:4095];

  always @(posedge clk) begin
    text_data <= tmem[text_addr];
    font_data <= fmem[font_addr];
  end

  typedef struct packed {
    logic [11:0] rgb;
    logic        b;
    logic        hs;
    logic        vs;
  } out_t;

  logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

  out_t        oq [$];
  logic [12:0] aq [$];
  logic [11:0] fq [$];
  int          total = 0;
  int          bad   = 0;
  int          since = 0;
  int          frames = 0;
  int          nstep = 0;
  logic        prev_vs;

  function automatic out_t model(input logic [11:0] h, input logic [11:0] v, input logic b,
                                 input logic hs, input logic vs);
    out_t        r;
    logic [6:0]  c;
    logic [5:0]  rw;
    logic [15:0] w;
    logic [7:0]  g;
    logic        p;
    c  = h[9:3];
    rw = v[9:4];
    w  = tmem[{rw, c}];
    g  = fmem[{w[7:0], v[3:0]}];
    p  = g[7 - int'(h[2:0])];
`ifdef VGA_TEXT_CURSOR_EN
    if (rw == cursor_row && c == cursor_col && v[3:0] >= 4'd14 && (frames % 32) < 16) p = 1'b1;
`endif
    r.rgb = b ? 12'h000 : pal[p ? w[11:8] : w[15:12]];
    r.b   = b;
    r.hs  = hs;
    r.vs  = vs;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flush_model();
    out_t idle;
    idle = '{rgb: 12'h000, b: 1'b1, hs: ~HP, vs: ~VP};
    oq = {};
    aq = {};
    fq = {};
    for (int i = 0; i < 5; i++) oq.push_back(idle);
    since   = 0;
    frames  = 0;
    prev_vs = ~VP;
  endtask

  task automatic drive_idle();
    hdata = '0; vdata = '0; blank_in = 1'b1; hsync_in = ~HP; vsync_in = ~VP;
  endtask

  task automatic step(input logic [11:0] h, input logic [11:0] v, input logic b,
                      input logic hs, input logic vs);
    out_t        e;
    logic [15:0] w;
    @(posedge clk);
    #1;
    hdata = h; vdata = v; blank_in = b; hsync_in = hs; vsync_in = vs;
    e = model(h, v, b, hs, vs);
    oq.push_back(e);
    w = tmem[{v[9:4], h[9:3]}];
    aq.push_back({v[9:4], h[9:3]});
    fq.push_back({w[7:0], v[3:0]});
    if (vs == VP && prev_vs != VP) frames++;
    prev_vs = vs;
    since++;
    nstep++;
    @(negedge clk);
    e = oq.pop_front();
    $display("step %0d h=%h v=%h b=%b rgb=%h want=%h", nstep, h, v, b, rgb, e.rgb);
    chk("rgb", {4'h0, rgb}, {4'h0, e.rgb});
    chk("blank", {15'h0, blank}, {15'h0, e.b});
    chk("hsync", {15'h0, hsync}, {15'h0, e.hs});
    chk("vsync", {15'h0, vsync}, {15'h0, e.vs});
    if (since >= 2) chk("text_addr", {3'h0, text_addr}, {3'h0, aq[aq.size()-2]});
    if (since >= 4) chk("font_addr", {4'h0, font_addr}, {4'h0, fq[fq.size()-4]});
    while (aq.size() > 5) void'(aq.pop_front());
    while (fq.size() > 5) void'(fq.pop_front());
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rgb", {4'h0, rgb}, 16'h0000);
    chk("rst_blank", {15'h0, blank}, 16'h0001);
    chk("rst_hsync", {15'h0, hsync}, {15'h0, ~HP});
    chk("rst_vsync", {15'h0, vsync}, {15'h0, ~VP});
    chk("rst_text_addr", {3'h0, text_addr}, 16'h0000);
    chk("rst_font_addr", {4'h0, font_addr}, 16'h0000);
  endtask

  initial begin
    logic [11:0] h, v;
    logic        b;
    for (int i = 0; i < 8192; i++) tmem[i] = 16'($urandom);
    for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
    tmem[13'h17FF] = 16'h1F41;
    fmem[12'h41E]  = 8'h81;
    tmem[{6'd2, 7'd3}] = 16'h1E20;
    for (int i = 0; i < 16; i++) fmem[{8'h20, 4'(i)}] = 8'h00;

    rst_n = 1'b0;
    cursor_col = 7'd3;
    cursor_row = 6'd2;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    flush_model();

    // addressing and pixel select across the cell at column 0x7F, row 0x2F
    for (int x = 0; x < 8; x++) step(12'h3F8 + 12'(x), 12'h2FE, 1'b0, ~HP, ~VP);
    // blanked pixel over a lit glyph bit, then a single-cycle hsync pulse
    step(12'h3F8, 12'h2FE, 1'b1, ~HP, ~VP);
    step(12'h3F9, 12'h2FE, 1'b0, HP, ~VP);
    for (int i = 0; i < 6; i++) step(12'h3FA, 12'h2FE, 1'b0, ~HP, ~VP);

    // cursor cell rows 14-15 across 34 frames of blink period
    for (int f = 0; f < 34; f++) begin
      for (int x = 24; x < 32; x += 3) begin
        step(12'(x), 12'd46, 1'b0, ~HP, ~VP);
        step(12'(x), 12'd47, 1'b0, ~HP, ~VP);
      end
      step(12'd0, 12'd0, 1'b1, ~HP, VP);
      step(12'd0, 12'd0, 1'b1, ~HP, ~VP);
    end

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        cursor_col = 7'($urandom);
        cursor_row = 6'($urandom_range(0, 47));
      end
      if ($urandom_range(0, 3) == 0) begin
        h = {2'b00, cursor_col, 3'($urandom)};
        v = {2'b00, cursor_row, 3'b111, 1'($urandom)};
      end else begin
        h = 12'($urandom_range(0, 1343));
        v = 12'($urandom_range(0, 805));
      end
      b = (h >= 12'd1024 || v >= 12'd768) ? 1'b1 : ($urandom_range(0, 15) == 0);
      step(h, v, b, ($urandom_range(0, 9) == 0) ? HP : ~HP, ($urandom_range(0, 7) == 0) ? VP : ~VP);

      if (n == 700) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        flush_model();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
